// File: rtl/rr_arbiter_8_if.sv
// rtl/rr_arbiter_8_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter_8_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout_pulse;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout_pulse
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - round-robin arbiter with registered one-hot grant and index
// Optional forced rotation after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_8_if.slave  arb
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic             pulse_q, pulse_n;
    logic [IDX_W-1:0] rel_ptr;

    // First set bit of r scanning base, base+1, ... with wrap-around.
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(base) + k) % N_REQ;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign rel_ptr = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CNT_W-1:0] hold_cnt, cnt_n;
    logic             at_limit;
    assign at_limit = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt <= '0;
        else        hold_cnt <= cnt_n;
    end
`else
    wire unused_max_hold = |MAX_HOLD;
`endif

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        pulse_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n   = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (|arb.req) begin
                    state_n = GRANT;
                    owner_n = pick(arb.req, ptr);
`ifdef ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            GRANT: begin
                if (!arb.req[owner]) begin
                    ptr_n = rel_ptr;
                    if (|arb.req) begin
                        owner_n = pick(arb.req, rel_ptr);
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt_n = '0;
                end else if (at_limit && |(arb.req & ~grant_q)) begin
                    // Owner still requests but someone else waits: rotate past it.
                    ptr_n   = rel_ptr;
                    owner_n = pick(arb.req, rel_ptr);
                    pulse_n = 1'b1;
                    cnt_n   = '0;
                end else if (!at_limit) begin
                    cnt_n = hold_cnt + 1'b1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
            end
        endcase
        grant_n = (state_n == GRANT) ? (N_REQ'(1) << owner_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            grant_q <= grant_n;
            pulse_q <= pulse_n;
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_idx     = owner;
    assign arb.grant_valid   = |grant_q;
    assign arb.timeout_pulse = pulse_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed-vector bench for rr_arbiter_8
module tb_rr_arbiter_8;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    rr_arbiter_8_if #(.N_REQ(8)) arb_if ();

    rr_arbiter_8 #(.N_REQ(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // idx < 0 means idle (no grant held)
    task automatic expect_grant(input string tag, input int idx, input bit pulse);
        if (idx < 0) begin
            check({tag, ".grant"}, 32'(arb_if.grant), 32'h0);
            check({tag, ".idx"},   32'(arb_if.grant_idx), 32'h0);
            check({tag, ".valid"}, 32'(arb_if.grant_valid), 32'h0);
        end else begin
            check({tag, ".grant"}, 32'(arb_if.grant), 32'(1) << idx);
            check({tag, ".idx"},   32'(arb_if.grant_idx), 32'(idx));
            check({tag, ".valid"}, 32'(arb_if.grant_valid), 32'h1);
        end
        check({tag, ".pulse"}, 32'(arb_if.timeout_pulse), 32'(pulse));
    endtask

    initial begin
        rst_n      = 1'b0;
        arb_if.req = 8'hFF;
        #2;
        expect_grant("rst_async", -1, 0);
        tick();
        expect_grant("rst_held1", -1, 0);
        tick();
        expect_grant("rst_held2", -1, 0);
        rst_n = 1'b1;
        expect_grant("rst_release", -1, 0);
        tick();
        expect_grant("post_rst_ff", 0, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("post_rst_idle", -1, 0);

        // single requester hold and release; ptr now 1
        arb_if.req = 8'h01; tick();
        expect_grant("t2_grant", 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_grant("t2_hold", 0, 0);
        end
        arb_if.req = 8'h00; tick();
        expect_grant("t2_release", -1, 0);
        arb_if.req = 8'h03; tick();
        expect_grant("t2_ptr1", 1, 0);
        arb_if.req = 8'h01; tick();
        expect_grant("t2_handoff", 0, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("t2_idle", -1, 0);

        // simultaneous 2 and 5, back-to-back handoff
        arb_if.req = 8'h24; tick();
        expect_grant("t3_first", 2, 0);
        arb_if.req = 8'h20; tick();
        expect_grant("t3_nobubble", 5, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("t3_idle", -1, 0);

        // ptr=6: 7 wins over 0, then wrap to 0
        arb_if.req = 8'h81; tick();
        expect_grant("t4_idx7", 7, 0);
        arb_if.req = 8'h01; tick();
        expect_grant("t4_wrap", 0, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("t4_idle", -1, 0);

        // late request waits behind current owner; ptr=1
        arb_if.req = 8'h03; tick();
        expect_grant("late_first", 1, 0);
        arb_if.req = 8'h13; tick();
        expect_grant("late_hold", 1, 0);
        arb_if.req = 8'h11; tick();
        expect_grant("late_served", 4, 0);
        arb_if.req = 8'h01; tick();
        expect_grant("late_wrap", 0, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("late_idle", -1, 0);

        // reset mid-grant, ptr=1 beforehand
        arb_if.req = 8'h08; tick();
        expect_grant("t6_grant3", 3, 0);
        #2 rst_n = 1'b0;
        #1 expect_grant("t6_async_drop", -1, 0);
        rst_n = 1'b1;
        tick();
        expect_grant("t6_regrant", 3, 0);
        #2 rst_n = 1'b0;
        arb_if.req = 8'h09;
        #1 expect_grant("t6_async_drop2", -1, 0);
        rst_n = 1'b1;
        tick();
        expect_grant("t6_ptr0", 0, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("t6_idle", -1, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;

`ifdef ARB_TIMEOUT_EN
        arb_if.req = 8'h03; tick();
        expect_grant("t5_c1", 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_grant("t5_hold", 0, 0);
        end
        tick();
        expect_grant("t5_rotate", 1, 1);
        tick();
        expect_grant("t5_after", 1, 0);
        arb_if.req = 8'h00; tick();
        expect_grant("t5_idle", -1, 0);
        arb_if.req = 8'h01; tick();
        expect_grant("t5_solo", 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_grant("t5_solo_hold", 0, 0);
        end
`else
        arb_if.req = 8'h03; tick();
        expect_grant("nto_grant", 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_grant("nto_hold", 0, 0);
        end
`endif
        arb_if.req = 8'h00; tick();
        expect_grant("final_idle", -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
